// File: rtl/regbank_write_queue_if.sv
// Bundle of the writeback, bank-write and forwarding signals of the register-bank write queue.
// slave: the queue itself; master: the surrounding pipeline/bank.
interface regbank_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a writeback request is transferred on a rising edge where
  // wb_valid and wb_ready are both high; wb_addr/wb_data must be stable
  // whenever wb_valid is high. reg_write is a one-cycle write strobe with no
  // back-pressure from the bank.
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              drain_stall;
  logic              flush;
  logic              reg_write;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data2;
  logic [CW-1:0]     count;
  logic              empty;

  modport slave (
    input  wb_valid, wb_addr, wb_data, drain_stall, flush, rd_addr1, rd_addr2,
    output wb_ready, reg_write, wr_addr, wr_data,
    output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
  );

  modport master (
    output wb_valid, wb_addr, wb_data, drain_stall, flush, rd_addr1, rd_addr2,
    input  wb_ready, reg_write, wr_addr, wr_data,
    input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty
  );
endinterface

// File: rtl/regbank_write_queue.sv
// Writeback FIFO draining one write per cycle into the register bank, with youngest-match forwarding.
// Optional WBQ_COALESCE_EN: pushes to an already-queued register merge into that entry.
module regbank_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  regbank_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              not_full;
  logic              is_empty;
  logic              do_pop;
  logic              do_alloc;
  logic              do_merge;
  logic              merge_hit;
  logic [PW-1:0]     merge_idx;
  logic [DEPTH-1:0]  valid_vec;

  assign not_full = (count_q < CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign do_pop   = !is_empty && !bus.drain_stall && !bus.flush;

  // Slot validity from its age relative to head; count, not pointer equality, bounds occupancy.
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

`ifdef WBQ_COALESCE_EN
  // The head leaving this edge cannot absorb a merge; such a push allocates instead.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_vec[i] && (addr_mem_q[i] == bus.wb_addr) &&
          !(do_pop && (PW'(i) == head_q))) begin
        merge_hit = 1'b1;
        merge_idx = PW'(i);
      end
    end
  end
  assign bus.wb_ready = not_full || merge_hit;
  assign do_merge     = bus.wb_valid && merge_hit && !bus.flush;
  assign do_alloc     = bus.wb_valid && !merge_hit && not_full && !bus.flush;
`else
  assign merge_hit    = 1'b0;
  assign merge_idx    = '0;
  assign bus.wb_ready = not_full;
  assign do_merge     = 1'b0;
  assign do_alloc     = bus.wb_valid && not_full && !bus.flush;
`endif

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (bus.flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_pop) begin
        reg_write_d = 1'b1;
        wr_addr_d   = addr_mem_q[head_q];
        wr_data_d   = data_mem_q[head_q];
        head_d      = head_q + PW'(1);
      end
      if (do_alloc) begin
        tail_d = tail_q + PW'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (do_alloc) begin
        addr_mem_q[tail_q] <= bus.wb_addr;
        data_mem_q[tail_q] <= bus.wb_data;
      end
      if (do_merge) begin
        data_mem_q[merge_idx] <= bus.wb_data;
      end
    end
  end

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    bus.fwd_hit1  = 1'b0;
    bus.fwd_data1 = '0;
    bus.fwd_hit2  = 1'b0;
    bus.fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (addr_mem_q[idx] == bus.rd_addr1) begin
          bus.fwd_hit1  = 1'b1;
          bus.fwd_data1 = data_mem_q[idx];
        end
        if (addr_mem_q[idx] == bus.rd_addr2) begin
          bus.fwd_hit2  = 1'b1;
          bus.fwd_data2 = data_mem_q[idx];
        end
      end
    end
  end

  assign bus.reg_write = reg_write_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
endmodule

// File: tb/tb_regbank_write_queue.sv
// Bench for regbank_write_queue: queue-of-entries reference model plus a write-port scoreboard.
// Build with +define+WBQ_COALESCE_EN to exercise the merging variant.
module tb_regbank_write_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int W      = ADDR_W + DATA_W;

  logic clock;
  logic reset;
  logic mon_en;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_q[$];

  regbank_write_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regbank_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // write-port monitor: a write is expected exactly when the model popped last cycle
  always @(negedge clock) begin
    if (mon_en) begin
      logic         exp_we;
      logic [W-1:0] e;
      exp_we = (exp_q.size() != 0);
      check("reg_write", {31'd0, bus.reg_write}, {31'd0, exp_we});
      if (exp_we) begin
        e = exp_q.pop_front();
        if (bus.reg_write) begin
          check("wr_addr", 32'(bus.wr_addr), 32'(e[W-1:DATA_W]));
          check("wr_data", 32'(bus.wr_data), 32'(e[DATA_W-1:0]));
        end
      end
    end
  end

  // driver: one cycle of stimulus, combinational checks, then the reference model step
  task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic st, input logic fl,
                      input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    int           m_size;
    int           m_idx;
    logic         m_pop;
    logic         m_ready;
    logic         h1, h2;
    logic [DATA_W-1:0] d1, d2;
    @(negedge clock);
    #1;
    bus.wb_valid    = v;
    bus.wb_addr     = a;
    bus.wb_data     = d;
    bus.drain_stall = st;
    bus.flush       = fl;
    bus.rd_addr1    = r1;
    bus.rd_addr2    = r2;
    #1;
    m_size = model_q.size();
    m_pop  = (m_size > 0) && !st && !fl;
    m_idx  = -1;
`ifdef WBQ_COALESCE_EN
    for (int j = 0; j < m_size; j++) begin
      if (model_q[j][W-1:DATA_W] == a && !(j == 0 && m_pop)) m_idx = j;
    end
`endif
    m_ready = (m_size < DEPTH) || (m_idx >= 0);
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    for (int j = m_size - 1; j >= 0; j--) begin
      if (!h1 && model_q[j][W-1:DATA_W] == r1) begin h1 = 1'b1; d1 = model_q[j][DATA_W-1:0]; end
      if (!h2 && model_q[j][W-1:DATA_W] == r2) begin h2 = 1'b1; d2 = model_q[j][DATA_W-1:0]; end
    end
    check("wb_ready",  {31'd0, bus.wb_ready}, {31'd0, m_ready});
    check("count",     32'(bus.count), 32'(m_size));
    check("empty",     {31'd0, bus.empty}, {31'd0, (m_size == 0)});
    check("fwd_hit1",  {31'd0, bus.fwd_hit1}, {31'd0, h1});
    check("fwd_data1", 32'(bus.fwd_data1), 32'(d1));
    check("fwd_hit2",  {31'd0, bus.fwd_hit2}, {31'd0, h2});
    check("fwd_data2", 32'(bus.fwd_data2), 32'(d2));
    if (fl) begin
      model_q.delete();
    end else begin
      if (m_pop) exp_q.push_back(model_q.pop_front());
      if (v && m_ready) begin
        if (m_idx >= 0) model_q[m_pop ? m_idx - 1 : m_idx] = {a, d};
        else            model_q.push_back({a, d});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 3'(i), 3'(i + 3));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.drain_stall = 1'b0; bus.flush = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr), 32'd0);
    check("rst_wr_data",   32'(bus.wr_data), 32'd0);
    check("rst_count",     32'(bus.count), 32'd0);
    check("rst_empty",     {31'd0, bus.empty}, 32'd1);
    check("rst_wb_ready",  {31'd0, bus.wb_ready}, 32'd1);
    check("rst_fwd_hit1",  {31'd0, bus.fwd_hit1}, 32'd0);
    check("rst_fwd_hit2",  {31'd0, bus.fwd_hit2}, 32'd0);
    mon_en = 1'b1;

    // single request, minimum latency
    step(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'd3, 3'd0);
    idle(3);

    // stalled fill, fifth request refused, then in-order drain
    for (int i = 0; i < 5; i++) step(1'b1, 3'(i), 16'(16'h0100 + i), 1'b1, 1'b0, 3'(i), 3'd7);
    idle(6);

    // youngest-match forwarding with duplicate addresses
    step(1'b1, 3'd5, 16'hAAAA, 1'b1, 1'b0, 3'd5, 3'd6);
    step(1'b1, 3'd5, 16'hBBBB, 1'b1, 1'b0, 3'd5, 3'd6);
    step(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd5, 3'd6);
    idle(4);

    // full queue under continuous push/drain, pointers wrap
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 4), 16'(16'h2000 + i), 1'b1, 1'b0, 3'd4, 3'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'(16'h3000 + i), 1'b0, 1'b0, 3'(i), 3'd2);
    idle(6);

    // flush with a same-cycle push
    for (int i = 0; i < 3; i++) step(1'b1, 3'(i + 1), 16'(16'h4000 + i), 1'b1, 1'b0, 3'd1, 3'd2);
    step(1'b1, 3'd7, 16'hDEAD, 1'b0, 1'b1, 3'd7, 3'd1);
    idle(4);

    // repeated register while stalled
    step(1'b1, 3'd2, 16'h0001, 1'b1, 1'b0, 3'd2, 3'd3);
    step(1'b1, 3'd2, 16'h0002, 1'b1, 1'b0, 3'd2, 3'd3);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(8);

    @(negedge clock);
    #2;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
